// File: rtl/pdp8_bin_loader_if.sv
// Tape byte stream and RAM write/read port of the PDP-8 BIN loader.
// master = loader side, slave = tape source / RAM side.
interface pdp8_bin_loader_if;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic [14:0] ram_addr;
   logic [11:0] ram_data_out;
   logic        ram_wr;
   logic        ram_rd;
   logic [11:0] ram_data_in;

   modport master (
      input  in_valid, in_data, ram_data_in,
      output in_ready, ram_addr, ram_data_out, ram_wr, ram_rd
   );

   modport slave (
      output in_valid, in_data, ram_data_in,
      input  in_ready, ram_addr, ram_data_out, ram_wr, ram_rd
   );
endinterface

// File: rtl/pdp8_bin_loader.sv
// PDP-8 BIN paper-tape loader: decodes the tape into RAM, checks the checksum, then releases the CPU.
// Define PDP8_LOADER_VERIFY_EN to read back and compare every written word.
module pdp8_bin_loader #(
   parameter int          LEADER_MIN = 8,
   parameter logic [11:0] START_PC   = 12'o0200
) (
   input  logic                      clk,
   input  logic                      reset,
   pdp8_bin_loader_if.master         bus,
   output logic                      cpu_reset,
   output logic [11:0]               start_pc,
   output logic [2:0]                start_if,
   output logic                      done,
   output logic                      cksum_err,
   output logic                      fmt_err,
   output logic                      verify_err
);

   typedef enum logic [3:0] {
      S_LEADER, S_SYNC, S_HI, S_LO, S_WR, S_RD, S_CMP, S_CHECK, S_DONE, S_ERR
   } state_t;

   state_t      state_q;
   logic [7:0]  lcnt_q;
   logic [2:0]  field_q;
   logic [11:0] addr_q;
   logic [11:0] sum_q;
   logic [6:0]  hi_q;
   logic        pend_vld_q;
   logic        pend_data_q;
   logic [6:0]  pend_hi_q;
   logic [6:0]  pend_lo_q;
   logic [11:0] pend_val_q;
   logic [14:0] pend_tgt_q;
   logic [14:0] wr_addr_q;
   logic [11:0] wr_data_q;
   logic [2:0]  start_if_q;
   logic        cpu_reset_q;
   logic        done_q;
   logic        cksum_err_q;
   logic        fmt_err_q;
   logic        verify_err_q;

   logic        take;
   logic        is_lead;
   logic        is_field;
   logic        is_frame;
   logic [11:0] word_d;
   logic [11:0] sum_d;

   assign is_lead  = (bus.in_data == 8'o200);
   assign is_field = (bus.in_data[7:6] == 2'b11);
   assign is_frame = ~bus.in_data[7];
   assign take     = bus.in_valid & bus.in_ready;
   assign word_d   = {hi_q[5:0], bus.in_data[5:0]};
   // The checksum covers the raw 7-bit frame values, including the class bit.
   assign sum_d    = sum_q + {5'd0, pend_hi_q} + {5'd0, pend_lo_q};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_LEADER;
         lcnt_q       <= '0;
         field_q      <= '0;
         addr_q       <= '0;
         sum_q        <= '0;
         pend_vld_q   <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         start_if_q   <= '0;
         cpu_reset_q  <= 1'b1;
         done_q       <= 1'b0;
         cksum_err_q  <= 1'b0;
         fmt_err_q    <= 1'b0;
         verify_err_q <= 1'b0;
      end else begin
         case (state_q)
            S_LEADER: if (take) begin
               if (!is_lead) begin
                  lcnt_q <= '0;
               end else if (lcnt_q == 8'(LEADER_MIN - 1)) begin
                  lcnt_q  <= '0;
                  state_q <= S_SYNC;
               end else begin
                  lcnt_q <= lcnt_q + 8'd1;
               end
            end
            S_SYNC, S_HI: if (take) begin
               if (is_lead) begin
                  if (state_q == S_HI) state_q <= S_CHECK;
               end else if (is_field) begin
                  field_q <= bus.in_data[5:3];
               end else if (is_frame) begin
                  hi_q    <= bus.in_data[6:0];
                  state_q <= S_LO;
               end
            end
            S_LO: if (take) begin
               if (is_frame) begin
                  state_q <= S_HI;
                  // Writes lag one word so the final (checksum) word is never stored.
                  if (pend_vld_q) begin
                     sum_q <= sum_d;
                     if (pend_data_q) begin
                        wr_addr_q <= pend_tgt_q;
                        wr_data_q <= pend_val_q;
                        state_q   <= S_WR;
                     end
                  end
                  if (hi_q[6]) begin
                     addr_q     <= word_d;
                     start_if_q <= field_q;
                  end else begin
                     pend_tgt_q <= {field_q, addr_q};
                     addr_q     <= addr_q + 12'd1;
                  end
                  pend_vld_q  <= 1'b1;
                  pend_data_q <= ~hi_q[6];
                  pend_hi_q   <= hi_q;
                  pend_lo_q   <= bus.in_data[6:0];
                  pend_val_q  <= word_d;
               end else begin
                  fmt_err_q <= 1'b1;
                  done_q    <= 1'b1;
                  state_q   <= S_ERR;
               end
            end
`ifdef PDP8_LOADER_VERIFY_EN
            S_WR:  state_q <= S_RD;
            S_RD:  state_q <= S_CMP;
            S_CMP: begin
               if (bus.ram_data_in != wr_data_q) begin
                  verify_err_q <= 1'b1;
                  done_q       <= 1'b1;
                  state_q      <= S_ERR;
               end else begin
                  state_q <= S_HI;
               end
            end
`else
            S_WR:  state_q <= S_HI;
`endif
            S_CHECK: begin
               done_q  <= 1'b1;
               state_q <= S_DONE;
               if (!pend_vld_q)                 fmt_err_q   <= 1'b1;
               else if (pend_val_q == sum_q)    cpu_reset_q <= 1'b0;
               else                             cksum_err_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready = ~reset & ((state_q == S_LEADER) || (state_q == S_SYNC) ||
                                   (state_q == S_HI)     || (state_q == S_LO));
   assign bus.ram_addr     = wr_addr_q;
   assign bus.ram_data_out = wr_data_q;
   assign bus.ram_wr       = (state_q == S_WR);

`ifdef PDP8_LOADER_VERIFY_EN
   assign bus.ram_rd = (state_q == S_RD);
   assign verify_err = verify_err_q;
`else
   logic unused_rd_data;
   logic unused_verify_q;
   assign unused_rd_data  = ^bus.ram_data_in;
   assign unused_verify_q = verify_err_q;
   assign bus.ram_rd      = 1'b0;
   assign verify_err      = 1'b0;
`endif

   assign cpu_reset = cpu_reset_q;
   assign start_pc  = START_PC;
   assign start_if  = start_if_q;
   assign done      = done_q;
   assign cksum_err = cksum_err_q;
   assign fmt_err   = fmt_err_q;

endmodule

// File: tb/tb_pdp8_bin_loader.sv
// Directed bench for pdp8_bin_loader: tape loads, checksum outcomes, field wrap, errors, reset mid-write.
module tb_pdp8_bin_loader;
   logic        clk;
   logic        reset;
   logic        cpu_reset;
   logic [11:0] start_pc;
   logic [2:0]  start_if;
   logic        done;
   logic        cksum_err;
   logic        fmt_err;
   logic        verify_err;

   int checks;
   int errors;

   pdp8_bin_loader_if bus ();

   pdp8_bin_loader #(.LEADER_MIN(8), .START_PC(12'o0200)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .cpu_reset  (cpu_reset),
      .start_pc   (start_pc),
      .start_if   (start_if),
      .done       (done),
      .cksum_err  (cksum_err),
      .fmt_err    (fmt_err),
      .verify_err (verify_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [11:0] mem [0:32767];
   logic [14:0] wlog_a [0:15];
   logic [11:0] wlog_d [0:15];
   int          wr_cnt;
   bit          rd_seen;
   bit          force_zero;

   // RAM model: write on strobe, read data registered one cycle after ram_rd
   always @(posedge clk) begin
      if (bus.ram_wr) begin
         mem[bus.ram_addr]    <= bus.ram_data_out;
         wlog_a[wr_cnt % 16] <= bus.ram_addr;
         wlog_d[wr_cnt % 16] <= bus.ram_data_out;
         wr_cnt              <= wr_cnt + 1;
      end
      if (bus.ram_rd) begin
         rd_seen         <= 1'b1;
         bus.ram_data_in <= force_zero ? 12'o0 : mem[bus.ram_addr];
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected finish within budget");
      $fatal(1, "watchdog");
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      wait_cycles(2);
      reset = 1'b0;
      wait_cycles(1);
   endtask

   task automatic try_byte(input logic [7:0] b, input int budget, output bit ok);
      int n;
      n  = 0;
      ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      while (bus.in_ready !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (bus.in_ready === 1'b1) begin
         @(negedge clk);
         ok = 1'b1;
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit ok;
      try_byte(b, 50, ok);
      if (!ok) begin
         errors++;
         $display("FAIL send_byte %o: got in_ready=%b, expected 1 within 50 cycles", b, bus.in_ready);
      end
   endtask

   task automatic leader(input int n);
      for (int i = 0; i < n; i++) send_byte(8'o200);
   endtask

   task automatic trailer();
      bit ok;
      for (int i = 0; i < 8; i++) begin
         try_byte(8'o200, 4, ok);
         if (!ok) break;
      end
      wait_cycles(2);
   endtask

   task automatic test_reset();
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      wait_cycles(2);
      checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL rst_cpu_reset: got %b expected 1", cpu_reset); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
      checks++; if ({cksum_err, fmt_err, verify_err} !== 3'b000) begin errors++; $display("FAIL rst_errs: got %b expected 000", {cksum_err, fmt_err, verify_err}); end
      checks++; if (start_pc !== 12'o0200) begin errors++; $display("FAIL rst_start_pc: got %o expected 0200", start_pc); end
      checks++; if (start_if !== 3'd0) begin errors++; $display("FAIL rst_start_if: got %0d expected 0", start_if); end
      checks++; if ({bus.in_ready, bus.ram_wr, bus.ram_rd} !== 3'b000) begin errors++; $display("FAIL rst_strobes: got %b expected 000", {bus.in_ready, bus.ram_wr, bus.ram_rd}); end
      checks++; if (bus.ram_addr !== 15'o0) begin errors++; $display("FAIL rst_ram_addr: got %o expected 0", bus.ram_addr); end
      reset = 1'b0;
      wait_cycles(1);
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b expected 1", bus.in_ready); end
   endtask

   task automatic test_cksum_bad();
      int base;
      do_reset();
      base = wr_cnt;
      leader(8);
      send_byte(8'o102); send_byte(8'o000);
      send_byte(8'o012); send_byte(8'o034);
      send_byte(8'o000); send_byte(8'o046);
      trailer();
      checks++; if (wr_cnt - base !== 1) begin errors++; $display("FAIL bad_wr_count: got %0d expected 1", wr_cnt - base); end
      checks++; if (mem[15'o00200] !== 12'o1234) begin errors++; $display("FAIL bad_mem200: got %o expected 1234", mem[15'o00200]); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL bad_done: got %b expected 1", done); end
      checks++; if (cksum_err !== 1'b1) begin errors++; $display("FAIL bad_cksum_err: got %b expected 1", cksum_err); end
      checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL bad_cpu_reset: got %b expected 1", cpu_reset); end
      checks++; if (fmt_err !== 1'b0) begin errors++; $display("FAIL bad_fmt_err: got %b expected 0", fmt_err); end
   endtask

   task automatic test_cksum_good();
      int base;
      do_reset();
      base = wr_cnt;
      leader(8);
      send_byte(8'o102); send_byte(8'o000);
      send_byte(8'o012); send_byte(8'o034);
      send_byte(8'o001); send_byte(8'o050);
      trailer();
      checks++; if (wr_cnt - base !== 1) begin errors++; $display("FAIL good_wr_count: got %0d expected 1", wr_cnt - base); end
      checks++; if (wlog_a[base % 16] !== 15'o00200 || wlog_d[base % 16] !== 12'o1234) begin errors++; $display("FAIL good_write: got %o/%o expected 00200/1234", wlog_a[base % 16], wlog_d[base % 16]); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL good_done: got %b expected 1", done); end
      checks++; if (cksum_err !== 1'b0) begin errors++; $display("FAIL good_cksum_err: got %b expected 0", cksum_err); end
      checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL good_cpu_reset: got %b expected 0", cpu_reset); end
      checks++; if (start_if !== 3'd0) begin errors++; $display("FAIL good_start_if: got %0d expected 0", start_if); end
   endtask

   task automatic test_field_wrap();
      int base;
      do_reset();
      base = wr_cnt;
      leader(8);
      send_byte(8'o330);
      send_byte(8'o177); send_byte(8'o077);
      send_byte(8'o000); send_byte(8'o001);
      send_byte(8'o000); send_byte(8'o002);
      send_byte(8'o003); send_byte(8'o001);
      trailer();
      checks++; if (wr_cnt - base !== 2) begin errors++; $display("FAIL wrap_wr_count: got %0d expected 2", wr_cnt - base); end
      checks++; if (wlog_a[base % 16] !== 15'o37777 || wlog_d[base % 16] !== 12'o0001) begin errors++; $display("FAIL wrap_first: got %o/%o expected 37777/0001", wlog_a[base % 16], wlog_d[base % 16]); end
      checks++; if (wlog_a[(base + 1) % 16] !== 15'o30000 || wlog_d[(base + 1) % 16] !== 12'o0002) begin errors++; $display("FAIL wrap_second: got %o/%o expected 30000/0002", wlog_a[(base + 1) % 16], wlog_d[(base + 1) % 16]); end
      checks++; if (start_if !== 3'd3) begin errors++; $display("FAIL wrap_start_if: got %0d expected 3", start_if); end
      checks++; if ({done, cksum_err, cpu_reset} !== 3'b100) begin errors++; $display("FAIL wrap_status: got %b expected 100", {done, cksum_err, cpu_reset}); end
   endtask

   task automatic test_short_leader();
      int base;
      do_reset();
      base = wr_cnt;
      leader(7);
      send_byte(8'o102); send_byte(8'o000);
      send_byte(8'o012); send_byte(8'o034);
      send_byte(8'o000); send_byte(8'o046);
      wait_cycles(3);
      checks++; if (wr_cnt - base !== 0) begin errors++; $display("FAIL short_wr_count: got %0d expected 0", wr_cnt - base); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL short_done: got %b expected 0", done); end
      checks++; if (bus.in_ready !== 1'b1 || cpu_reset !== 1'b1) begin errors++; $display("FAIL short_state: got ready=%b cpu_reset=%b expected 1 1", bus.in_ready, cpu_reset); end
   endtask

   task automatic test_fmt_err();
      do_reset();
      leader(8);
      send_byte(8'o102);
      send_byte(8'o200);
      wait_cycles(2);
      checks++; if (fmt_err !== 1'b1) begin errors++; $display("FAIL fmt_flag: got %b expected 1", fmt_err); end
      checks++; if (done !== 1'b1 || cpu_reset !== 1'b1) begin errors++; $display("FAIL fmt_status: got done=%b cpu_reset=%b expected 1 1", done, cpu_reset); end
      wait_cycles(3);
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fmt_ready: got %b expected 0", bus.in_ready); end
      checks++; if (cksum_err !== 1'b0) begin errors++; $display("FAIL fmt_cksum: got %b expected 0", cksum_err); end
   endtask

   task automatic test_reset_mid_write();
      int base;
      do_reset();
      leader(8);
      send_byte(8'o102); send_byte(8'o000);
      send_byte(8'o012); send_byte(8'o034);
      send_byte(8'o000); send_byte(8'o046);
      checks++; if (bus.ram_wr !== 1'b1) begin errors++; $display("FAIL midwr_strobe: got %b expected 1", bus.ram_wr); end
      reset = 1'b1;
      @(negedge clk);
      checks++; if (bus.ram_wr !== 1'b0) begin errors++; $display("FAIL midwr_drop: got %b expected 0", bus.ram_wr); end
      checks++; if ({cpu_reset, done, cksum_err, fmt_err, bus.in_ready} !== 5'b10000) begin errors++; $display("FAIL midwr_outputs: got %b expected 10000", {cpu_reset, done, cksum_err, fmt_err, bus.in_ready}); end
      checks++; if (bus.ram_addr !== 15'o0 || start_if !== 3'd0) begin errors++; $display("FAIL midwr_addr: got %o/%0d expected 0/0", bus.ram_addr, start_if); end
      reset = 1'b0;
      wait_cycles(1);
      base = wr_cnt;
      leader(8);
      send_byte(8'o103); send_byte(8'o000);
      send_byte(8'o012); send_byte(8'o034);
      send_byte(8'o001); send_byte(8'o051);
      trailer();
      checks++; if (wr_cnt - base !== 1) begin errors++; $display("FAIL reload_wr_count: got %0d expected 1", wr_cnt - base); end
      checks++; if (wlog_a[base % 16] !== 15'o00300 || wlog_d[base % 16] !== 12'o1234) begin errors++; $display("FAIL reload_write: got %o/%o expected 00300/1234", wlog_a[base % 16], wlog_d[base % 16]); end
      checks++; if ({done, cksum_err, cpu_reset} !== 3'b100) begin errors++; $display("FAIL reload_status: got %b expected 100", {done, cksum_err, cpu_reset}); end
   endtask

`ifdef PDP8_LOADER_VERIFY_EN
   task automatic test_verify();
      force_zero = 1'b1;
      do_reset();
      leader(8);
      send_byte(8'o102); send_byte(8'o000);
      send_byte(8'o012); send_byte(8'o034);
      send_byte(8'o000); send_byte(8'o046);
      wait_cycles(4);
      checks++; if (verify_err !== 1'b1) begin errors++; $display("FAIL verify_flag: got %b expected 1", verify_err); end
      checks++; if ({done, cpu_reset, bus.in_ready} !== 3'b110) begin errors++; $display("FAIL verify_status: got %b expected 110", {done, cpu_reset, bus.in_ready}); end
      force_zero = 1'b0;
   endtask
`else
   task automatic test_verify();
      checks++; if (rd_seen !== 1'b0) begin errors++; $display("FAIL noverify_rd: got %b expected 0", rd_seen); end
      checks++; if (verify_err !== 1'b0) begin errors++; $display("FAIL noverify_flag: got %b expected 0", verify_err); end
   endtask
`endif

   initial begin
      checks       = 0;
      errors       = 0;
      force_zero   = 1'b0;
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      @(negedge clk);
      test_reset();
      test_cksum_bad();
      test_cksum_good();
      test_field_wrap();
      test_short_leader();
      test_fmt_err();
      test_reset_mid_write();
      test_verify();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pdp8_bin_loader.md
Name: pdp8_bin_loader

Overview:
- Power-on loader upstream of pdp8 and pdp8_ram.
- Consumes a BIN-format paper-tape byte stream and writes the decoded words into RAM through the CPU RAM port.
- Holds the CPU in reset until the tape trailer arrives and the checksum passes.
- Supplies the start PC and instruction field to the CPU on release.

Parameters:
- LEADER_MIN, 8: number of consecutive 0200 bytes required before body decode starts.
- START_PC, 12'o0200: value driven on start_pc.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  tape byte present.
- in_data  in  8  tape byte.
- in_ready  out  1  byte accepted when in_valid&in_ready at a rising edge.
- ram_addr  out  15  {field,addr} for write/read.
- ram_data_out  out  12  write data.
- ram_wr  out  1  one-cycle write strobe.
- ram_rd  out  1  one-cycle read strobe (verify only).
- ram_data_in  in  12  read data, valid the cycle after ram_rd.
- cpu_reset  out  1  held high until a successful load.
- start_pc  out  12  START_PC.
- start_if  out  3  field of the last origin seen.
- done  out  1  trailer processed.
- cksum_err  out  1  checksum mismatch.
- fmt_err  out  1  malformed tape.
- verify_err  out  1  readback mismatch.

Behaviour:
- Reset values (next edge with reset=1, from any state):
  - cpu_reset=1; all other outputs 0.
  - start_pc=START_PC; start_if=0.
  - Internal state cleared: sum=0, field=0, addr=0, pending invalid.
- Byte classes:
  - 0200: leader/trailer.
  - 11xxx xxx (0300-0377): field setting, field=in_data[5:3].
  - 01xx xxxx: origin frame.
  - 00xx xxxx: data frame.
  - Any other byte with bit7=1: discarded, no state change.
- A word is two frames: first frame supplies bits 11:6, second frame bits 5:0. Both frames take their class from the first frame.
- States:
  - S_LEADER: count consecutive 0200 bytes; any other byte clears the count. On reaching LEADER_MIN go to S_SYNC.
  - S_SYNC: further 0200 bytes ignored. A field byte updates field. An origin or data byte is the first frame; go to S_LO.
  - S_HI: 0200 is the trailer; go to S_CHECK. A field byte updates field. An origin or data byte is the first frame; go to S_LO.
  - S_LO: any 00/01 byte is the second frame and completes the word. Any other byte sets fmt_err and goes to S_ERR.
- Word completion, performed in order:
  - If a pending word exists, its first- and second-frame byte values (bits 6:0) are added into sum (12-bit, mod 4096).
  - If that pending word is data, go to S_WR.
  - Origin word: addr=value; start_if=field.
  - Data word: latch target {field,addr}; addr=addr+1, wrapping 07777->0000 within the field, field unchanged.
  - The new word becomes pending.
- Write deferral: the last word before the trailer is the checksum and is never written.
- S_WR: one cycle with ram_wr=1 and ram_addr/ram_data_out = the committed word; in_ready=0; then go to S_HI.
- in_ready=1 only in S_LEADER/S_SYNC/S_HI/S_LO; 0 in all other states.
- S_CHECK: compare the pending word value to sum.
  - Equal: done=1, cpu_reset=0.
  - Unequal: done=1, cksum_err=1, cpu_reset stays 1.
  - No pending word: fmt_err=1.
  - Then go to S_DONE.
- S_DONE/S_ERR: terminal until reset; outputs hold. S_ERR drives done=1 with cpu_reset=1.
- Reset mid-write: the strobe is dropped the same edge; the partial load is not completed.

Optional Feature:
- PDP8_LOADER_VERIFY_EN defined:
  - After each S_WR: S_RD (ram_rd=1, same address), then S_CMP.
  - S_CMP compares ram_data_in to the written word; a mismatch sets verify_err and goes to S_ERR.
  - Each data word costs 3 cycles.
- Undefined: ram_rd=0 and verify_err=0 constantly; ram_data_in is unused.

Test Plan:
- 8x0200, 0102 0000, 0012 0034, 0000 0046, 8x0200 -> one write, mem[00200]=1234; sum=0102+0000+0012+0034=0150; checksum word 0046 != 0150 so cksum_err=1, cpu_reset=1. With checksum frames 0001 0050 (=0150) instead: done=1, cksum_err=0, cpu_reset=0.
- Field byte 0330, origin 0177 0077 (07777), data words 0001,0002, checksum -> writes at 37777 then 30000 (in-field wrap); start_if=3.
- Only 7 leading 0200 bytes then body -> stays in S_LEADER, no writes, done=0.
- 0200 arriving in S_LO -> fmt_err=1, done=1, cpu_reset=1, in_ready=0 thereafter.
- Assert reset during S_WR -> ram_wr low next edge; all outputs at reset values; a fresh tape then loads correctly.
- With PDP8_LOADER_VERIFY_EN and RAM forced to return 0000 -> verify_err=1 after the first data word.
